mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter sharing the single memory port between the multi-cycle CPU's control/datapath (port cpu) and a DMA/debug master (port dma). It sits between the CPU's memory interface and the memory/MIO bus. Each transaction moves through a small FSM: arbitrate, hold the access until the memory acknowledges, then return a one-cycle ready pulse. For the CPU, that pulse is the `MIO_ready` input of the control FSM.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `TIMEOUT`, default 15: maximum ACCESS cycles without `mem_ack`. Used only with `MEM_ARB_TIMEOUT_EN`.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cpu_req` in 1: CPU request, held until `cpu_ready`.
- `cpu_we` in 1: 1 = write, 0 = read.
- `cpu_addr` in ADDR_W
- `cpu_wdata` in DATA_W
- `cpu_rdata` out DATA_W: read data, valid while `cpu_ready`=1, held afterwards.
- `cpu_ready` out 1: one-cycle completion pulse.
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_rdata`, `dma_ready`: same as cpu_* for the DMA port.
- `mem_en` out 1: memory access strobe, high for the whole ACCESS state.
- `mem_we` out 1
- `mem_addr` out ADDR_W
- `mem_wdata` out DATA_W
- `mem_rdata` in DATA_W
- `mem_ack` in 1: memory completion, sampled on `clk`.
- `owner` out 1: 0 = cpu, 1 = dma. Current or last grant.
- `timeout_err` out 1: one-cycle error pulse, coincident with ready.

## Operation
- States: IDLE, ACCESS, DONE. Reset state is IDLE.
- **IDLE:**
  - If either req=1, select the winner, latch its we/addr/wdata into the mem_* registers, set `owner`, and go to ACCESS.
  - If no req, stay in IDLE.
- **Arbitration** is round-robin on `last_owner`:
  - Only one request: that port wins.
  - Both request: the port other than `last_owner` wins.
- **ACCESS:**
  - `mem_en`=1; mem_we/addr/wdata stay stable from the latch.
  - On `mem_ack`=1: capture `mem_rdata` into the winner's rdata register (for writes too), set `last_owner`=winner, go to DONE.
- **DONE:**
  - `mem_en`=0 and the winner's ready=1 for exactly one cycle, then go to IDLE.
  - The losing port's ready and rdata are unchanged.
- **Request rules:**
  - A requester holds req and its operands until its ready.
  - Req deasserted during ACCESS is ignored; the transaction completes and still pulses ready.
  - Req still high in the cycle after DONE is a new request.
- **Outputs outside ACCESS:**
  - `mem_en`=0 and `mem_we`=0.
  - mem_addr/mem_wdata hold their last values.
- **Reset values:**
  - All outputs 0, including `owner`, both rdata, both ready, and `timeout_err`.
  - `last_owner`=1, so the cpu wins the first tie.
  - Timeout counter = 0.
- **Reset mid-transaction:**
  - Any asserted reset returns the FSM to IDLE on the next edge.
  - No ready pulse; `mem_en` is 0 in the following cycle.
  - rdata is cleared.

## Timing
- Cycle numbering:
  - Cycle t: IDLE, req high.
  - Cycle t+1: ACCESS, `mem_en`=1.
  - ACK at cycle t+1+k: DONE and ready at cycle t+2+k.
- Minimum latency req→ready is 2 cycles (`mem_ack` high in the first ACCESS cycle).
- Back-to-back: the earliest next `mem_en` is 2 cycles after the ready cycle (DONE → IDLE → ACCESS). Memory throughput is therefore at most one access per 3 cycles.
- `mem_ack` is ignored outside ACCESS.
- `mem_ack` is not required to drop between transactions. An ack already high in the first ACCESS cycle completes the access immediately.

## Configuration
- Macro `MEM_ARB_TIMEOUT_EN`.
- **Defined:**
  - The counter clears on entering ACCESS and increments in each ACCESS cycle without ack.
  - When it reaches `TIMEOUT` with `mem_ack`=0, go to DONE with the winner's rdata = all-ones, ready=1 and `timeout_err`=1 in that same cycle.
  - If ack and counter==`TIMEOUT` occur in the same cycle, ack wins: normal data, no error.
  - `last_owner` updates as normal.
- **Undefined:**
  - No counter; ACCESS waits indefinitely.
  - `timeout_err` is tied to 0.

## Test plan
- Reset, then idle: all outputs 0. CPU read addr 0x10, memory acks on the first ACCESS cycle with rdata 0x1234_5678 → `cpu_ready` 2 cycles after req, `cpu_rdata`=0x1234_5678, `owner`=0.
- Both req in the same cycle after reset → cpu served first, then dma. Repeat with both held → grants alternate cpu, dma, cpu, dma.
- DMA write addr 0x40, data 0xCAFE_F00D, ack delayed 4 cycles → `mem_en` high for 5 cycles with `mem_we`=1, stable addr/wdata; `dma_ready` in the cycle after ack; `cpu_ready` stays 0.
- Reset asserted during ACCESS → next cycle IDLE with `mem_en`=0; no ready pulse; rdata cleared.
- cpu_req dropped mid-ACCESS → transaction still completes; `cpu_ready` pulses once.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT`=15, and ack never asserted → ready and `timeout_err` pulse together after 15 ACCESS cycles with rdata=0xFFFF_FFFF. Ack on exactly cycle 15 → normal completion, `timeout_err`=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between the multi-cycle CPU (cpu_*) and a DMA/debug
// master (dma_*). Each transaction runs IDLE -> ACCESS -> DONE: the winner's
// operands are latched on the grant, held on mem_* while memory works, and
// DONE returns a one-cycle ready pulse to the winner together with its data.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   cpu_req/we/addr/wdata   CPU request and operands (held until cpu_ready)
//   cpu_rdata/cpu_ready     CPU read data (held) and completion pulse
//   dma_*                   same set for the DMA port
//   mem_en/we/addr/wdata    memory strobe and latched operands
//   mem_rdata, mem_ack      memory read data and completion
//   owner                   current or last grant (0 = cpu, 1 = dma)
//   timeout_err             error pulse, coincident with ready
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to bound ACCESS at TIMEOUT
// cycles without mem_ack; the stalled access then completes with all-ones
// data and a timeout_err pulse.

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              owner,
    output logic              timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic last_owner;
    logic we_reg;
    logic grant;
    logic winner;
    logic timeout_hit;

    // Round-robin pick: a lone requester always wins; on a tie the port that
    // was not served last goes next, so neither master can starve the other.
    always_comb begin
        grant  = cpu_req | dma_req;
        winner = 1'b0;
        if (cpu_req && dma_req) begin
            winner = ~last_owner;
        end else if (dma_req) begin
            winner = 1'b1;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_flag;

    // wait_cnt holds the number of ack-less ACCESS cycles already finished,
    // so the current cycle is the TIMEOUT-th one when it equals TIMEOUT-1.
    // An ack arriving in that very cycle still completes normally.
    assign timeout_hit = (state == ACCESS) && !mem_ack && (wait_cnt == LAST_CNT);

    // The counter restarts on every grant and only advances while memory has
    // not answered; err_flag marks a DONE that was reached by timing out.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    err_flag <= 1'b0;
                end
                ACCESS: begin
                    if (!mem_ack) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                    err_flag <= timeout_hit;
                end
                default: begin
                    err_flag <= 1'b0;
                end
            endcase
        end
    end

    assign timeout_err = (state == DONE) && err_flag;
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. mem_ack only matters in ACCESS, and DONE always lasts
    // exactly one cycle so the ready pulse cannot stretch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath registers. Operands are captured once at the grant so the
    // memory sees stable values even if the requester misbehaves; the
    // winner's rdata is written on completion (for writes as well) and the
    // other port's rdata is never touched.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            we_reg     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner     <= winner;
                        we_reg    <= winner ? dma_we    : cpu_we;
                        mem_addr  <= winner ? dma_addr  : cpu_addr;
                        mem_wdata <= winner ? dma_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    if (mem_ack || timeout_hit) begin
                        last_owner <= owner;
                        if (owner) begin
                            dma_rdata <= mem_ack ? mem_rdata : '1;
                        end else begin
                            cpu_rdata <= mem_ack ? mem_rdata : '1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes are pure state decodes: mem_we is forced low outside ACCESS,
    // and only the owning port sees the DONE pulse.
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_en & we_reg;
    assign cpu_ready = (state == DONE) && !owner;
    assign dma_ready = (state == DONE) && owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter. A transaction-level reference
// model (who should win, how many cycles the access lasts, what each port's
// rdata should hold) is kept in plain variables and compared against the DUT.
// Follows MEM_ARB_TIMEOUT_EN the same way the design does.

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata;
    logic        cpu_ready, dma_ready;
    logic        mem_en, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner, timeout_err;

    int checks = 0;
    int errors = 0;

    int          model_last;
    logic [31:0] exp_cpu_rdata;
    logic [31:0] exp_dma_rdata;

    int          r_who;
    int          r_lat;
    int          r_en;
    bit          r_stable;
    bit          r_other;
    logic        r_we;
    logic        r_own;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ready(dma_ready),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse reset for one edge and return the model to its reset view.
    task automatic do_reset;
        reset   = 1'b1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_last    = 1;
        exp_cpu_rdata = '0;
        exp_dma_rdata = '0;
    endtask

    // Drives one arbitration round starting in an IDLE cycle and acts as the
    // memory: ack is given in ACCESS cycle ack_delay+1 (never if negative).
    // Observations land in the r_* variables; no judgement is made here.
    task automatic run_txn(input logic creq, input logic cwe, input logic [31:0] cad,
                           input logic [31:0] cwd, input logic dreq, input logic dwe,
                           input logic [31:0] dad, input logic [31:0] dwd,
                           input int ack_delay, input logic [31:0] rval, input bit drop_early);
        @(posedge clk); #1;
        cpu_req = creq; cpu_we = cwe; cpu_addr = cad; cpu_wdata = cwd;
        dma_req = dreq; dma_we = dwe; dma_addr = dad; dma_wdata = dwd;
        r_who = -1; r_lat = -1; r_en = 0; r_stable = 1'b1; r_other = 1'b0;
        r_we = 1'bx; r_own = 1'bx; r_err = 1'bx;
        r_addr = 'x; r_wdata = 'x; r_rdata = 'x;
        for (int c = 0; c < 100 && r_who < 0; c++) begin
            @(negedge clk);
            if (cpu_ready || dma_ready) begin
                r_who   = dma_ready ? 1 : 0;
                r_other = cpu_ready && dma_ready;
                r_lat   = c;
                r_rdata = dma_ready ? dma_rdata : cpu_rdata;
                r_own   = owner;
                r_err   = timeout_err;
                cpu_req = 1'b0;
                dma_req = 1'b0;
                mem_ack = 1'b0;
            end else begin
                if (mem_en) begin
                    r_en++;
                    if (r_en == 1) begin
                        r_we = mem_we; r_addr = mem_addr; r_wdata = mem_wdata;
                    end else if (mem_we !== r_we || mem_addr !== r_addr || mem_wdata !== r_wdata) begin
                        r_stable = 1'b0;
                    end
                    if (drop_early) begin
                        cpu_req = 1'b0;
                        dma_req = 1'b0;
                    end
                end
                mem_ack   = mem_en && (r_en == ack_delay + 1);
                mem_rdata = mem_ack ? rval : $urandom();
            end
        end
        if (r_who < 0) begin
            cpu_req = 1'b0;
            dma_req = 1'b0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({mem_en, mem_we, owner, cpu_ready, dma_ready, timeout_err} !== 6'b0) begin errors++; $display("[TB] FAIL reset.flags got %b expected 000000", {mem_en, mem_we, owner, cpu_ready, dma_ready, timeout_err}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset.mem_addr got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset.mem_wdata got %h expected 0", mem_wdata); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset.cpu_rdata got %h expected 0", cpu_rdata); end
        checks++; if (dma_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset.dma_rdata got %h expected 0", dma_rdata); end
        @(posedge clk); #1;
        reset = 1'b0;
        model_last    = 1;
        exp_cpu_rdata = '0;
        exp_dma_rdata = '0;
    endtask

    task automatic test_cpu_read;
        run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h1234_5678, 1'b0);
        checks++; if (r_who !== 0) begin errors++; $display("[TB] FAIL cpu_read.winner got %0d expected 0", r_who); end
        checks++; if (r_lat !== 2) begin errors++; $display("[TB] FAIL cpu_read.latency got %0d expected 2", r_lat); end
        checks++; if (r_rdata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL cpu_read.rdata got %h expected 12345678", r_rdata); end
        checks++; if (r_own !== 1'b0) begin errors++; $display("[TB] FAIL cpu_read.owner got %b expected 0", r_own); end
        checks++; if (r_addr !== 32'h10 || r_we !== 1'b0) begin errors++; $display("[TB] FAIL cpu_read.mem_op got addr %h we %b expected addr 10 we 0", r_addr, r_we); end
        model_last    = 0;
        exp_cpu_rdata = 32'h1234_5678;
    endtask

    task automatic test_ack_idle;
        @(posedge clk); #1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({mem_en, cpu_ready, dma_ready} !== 3'b000) begin errors++; $display("[TB] FAIL ack_idle.cycle%0d got en/ready %b expected 000", i, {mem_en, cpu_ready, dma_ready}); end
        end
        mem_ack = 1'b0;
    endtask

    task automatic test_tie;
        int exp_w;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_w = (i % 2 == 0) ? 0 : 1;
            run_txn(1'b1, 1'b0, 32'h100 + i, 32'h0, 1'b1, 1'b0, 32'h200 + i, 32'h0, i % 3, 32'hA000_0000 + i, 1'b0);
            checks++; if (r_who !== exp_w) begin errors++; $display("[TB] FAIL tie.grant%0d got %0d expected %0d", i, r_who, exp_w); end
            checks++; if (r_addr !== (exp_w == 1 ? 32'h200 + i : 32'h100 + i)) begin errors++; $display("[TB] FAIL tie.addr%0d got %h", i, r_addr); end
            model_last = exp_w;
            if (exp_w == 1) exp_dma_rdata = 32'hA000_0000 + i;
            else            exp_cpu_rdata = 32'hA000_0000 + i;
        end
    endtask

    task automatic test_dma_write;
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D, 4, 32'h0BAD_BEEF, 1'b0);
        checks++; if (r_who !== 1) begin errors++; $display("[TB] FAIL dma_write.winner got %0d expected 1", r_who); end
        checks++; if (r_en !== 5) begin errors++; $display("[TB] FAIL dma_write.en_cycles got %0d expected 5", r_en); end
        checks++; if (r_lat !== 6) begin errors++; $display("[TB] FAIL dma_write.latency got %0d expected 6", r_lat); end
        checks++; if (!r_stable || r_we !== 1'b1 || r_addr !== 32'h40 || r_wdata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL dma_write.mem_op got stable %b we %b addr %h wdata %h expected 1 1 40 cafef00d", r_stable, r_we, r_addr, r_wdata); end
        checks++; if (r_other !== 1'b0) begin errors++; $display("[TB] FAIL dma_write.cpu_ready got 1 expected 0"); end
        checks++; if (r_rdata !== 32'h0BAD_BEEF) begin errors++; $display("[TB] FAIL dma_write.rdata got %h expected 0badbeef", r_rdata); end
        checks++; if (cpu_rdata !== exp_cpu_rdata) begin errors++; $display("[TB] FAIL dma_write.cpu_rdata got %h expected %h", cpu_rdata, exp_cpu_rdata); end
        model_last    = 1;
        exp_dma_rdata = 32'h0BAD_BEEF;
        @(negedge clk);
        checks++; if ({mem_en, mem_we, cpu_ready, dma_ready} !== 4'b0000 || mem_addr !== 32'h40) begin errors++; $display("[TB] FAIL dma_write.after got en/we/ready %b addr %h expected 0000 addr 40", {mem_en, mem_we, cpu_ready, dma_ready}, mem_addr); end
    endtask

    task automatic test_req_drop;
        run_txn(1'b1, 1'b0, 32'h88, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3, 32'h5555_AAAA, 1'b1);
        checks++; if (r_who !== 0) begin errors++; $display("[TB] FAIL req_drop.winner got %0d expected 0", r_who); end
        checks++; if (r_lat !== 5) begin errors++; $display("[TB] FAIL req_drop.latency got %0d expected 5", r_lat); end
        checks++; if (r_rdata !== 32'h5555_AAAA) begin errors++; $display("[TB] FAIL req_drop.rdata got %h expected 5555aaaa", r_rdata); end
        model_last    = 0;
        exp_cpu_rdata = 32'h5555_AAAA;
        @(negedge clk);
        checks++; if (cpu_ready !== 1'b0) begin errors++; $display("[TB] FAIL req_drop.single_pulse got %b expected 0", cpu_ready); end
    endtask

    task automatic test_random;
        bit          p_c, p_d;
        logic        c_we, d_we;
        logic [31:0] c_ad, c_wd, d_ad, d_wd, rv;
        int          k, exp_w;
        p_c = 1'b0;
        p_d = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!p_c) begin
                p_c = 1'($urandom_range(0, 1));
                c_we = 1'($urandom_range(0, 1)); c_ad = $urandom(); c_wd = $urandom();
            end
            if (!p_d) begin
                p_d = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1)); d_ad = $urandom(); d_wd = $urandom();
            end
            if (!p_c && !p_d) p_c = 1'b1;
            k  = $urandom_range(0, 4);
            rv = $urandom();
            if (p_c && p_d) exp_w = (model_last == 1) ? 0 : 1;
            else            exp_w = p_d ? 1 : 0;
            run_txn(p_c, c_we, c_ad, c_wd, p_d, d_we, d_ad, d_wd, k, rv, 1'b0);
            checks++; if (r_who !== exp_w) begin errors++; $display("[TB] FAIL random%0d.winner got %0d expected %0d", i, r_who, exp_w); end
            checks++; if (r_lat !== k + 2 || r_en !== k + 1) begin errors++; $display("[TB] FAIL random%0d.timing got lat %0d en %0d expected %0d %0d", i, r_lat, r_en, k + 2, k + 1); end
            checks++; if (!r_stable || r_addr !== (exp_w == 1 ? d_ad : c_ad) || r_wdata !== (exp_w == 1 ? d_wd : c_wd) || r_we !== (exp_w == 1 ? d_we : c_we)) begin errors++; $display("[TB] FAIL random%0d.mem_op got stable %b we %b addr %h wdata %h", i, r_stable, r_we, r_addr, r_wdata); end
            checks++; if (r_rdata !== rv || r_own !== exp_w[0] || r_err !== 1'b0) begin errors++; $display("[TB] FAIL random%0d.result got rdata %h owner %b err %b expected %h %0d 0", i, r_rdata, r_own, r_err, rv, exp_w); end
            if (exp_w == 1) begin
                checks++; if (cpu_rdata !== exp_cpu_rdata) begin errors++; $display("[TB] FAIL random%0d.cpu_rdata got %h expected %h", i, cpu_rdata, exp_cpu_rdata); end
                exp_dma_rdata = rv;
                p_d = 1'b0;
            end else begin
                checks++; if (dma_rdata !== exp_dma_rdata) begin errors++; $display("[TB] FAIL random%0d.dma_rdata got %h expected %h", i, dma_rdata, exp_dma_rdata); end
                exp_cpu_rdata = rv;
                p_c = 1'b0;
            end
            model_last = exp_w;
        end
    endtask

    task automatic test_reset_mid;
        bit seen_ready;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h77; mem_ack = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_en !== 1'b1) begin errors++; $display("[TB] FAIL reset_mid.access got mem_en %b expected 1", mem_en); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        checks++; if ({mem_en, cpu_ready, dma_ready} !== 3'b000) begin errors++; $display("[TB] FAIL reset_mid.idle got en/ready %b expected 000", {mem_en, cpu_ready, dma_ready}); end
        checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mid.rdata got %h %h expected 0 0", cpu_rdata, dma_rdata); end
        seen_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_ready || dma_ready || mem_en) seen_ready = 1'b1;
        end
        checks++; if (seen_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_mid.quiet got activity expected none"); end
        model_last    = 1;
        exp_cpu_rdata = '0;
        exp_dma_rdata = '0;
        run_txn(1'b1, 1'b1, 32'h11, 32'h22, 1'b1, 1'b0, 32'h33, 32'h0, 1, 32'h6666_7777, 1'b0);
        checks++; if (r_who !== 0) begin errors++; $display("[TB] FAIL reset_mid.first_tie got %0d expected 0", r_who); end
        model_last    = 0;
        exp_cpu_rdata = 32'h6666_7777;
    endtask

    task automatic test_timeout;
`ifdef MEM_ARB_TIMEOUT_EN
        run_txn(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, -1, 32'h0, 1'b0);
        checks++; if (r_who !== 0 || r_lat !== 16 || r_en !== 15) begin errors++; $display("[TB] FAIL timeout.timing got who %0d lat %0d en %0d expected 0 16 15", r_who, r_lat, r_en); end
        checks++; if (r_err !== 1'b1 || r_rdata !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL timeout.error got err %b rdata %h expected 1 ffffffff", r_err, r_rdata); end
        run_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h304, 32'h0, 14, 32'h1357_9BDF, 1'b0);
        checks++; if (r_who !== 1 || r_lat !== 16) begin errors++; $display("[TB] FAIL timeout.edge_timing got who %0d lat %0d expected 1 16", r_who, r_lat); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL timeout.edge_ack got err %b rdata %h expected 0 13579bdf", r_err, r_rdata); end
`else
        run_txn(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 20, 32'h2468_ACE0, 1'b0);
        checks++; if (r_who !== 0 || r_lat !== 22 || r_en !== 21) begin errors++; $display("[TB] FAIL long_wait.timing got who %0d lat %0d en %0d expected 0 22 21", r_who, r_lat, r_en); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'h2468_ACE0) begin errors++; $display("[TB] FAIL long_wait.result got err %b rdata %h expected 0 2468ace0", r_err, r_rdata); end
`endif
    endtask

    initial begin
        reset   = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        $display("[TB] starting mem_port_arbiter bench");
        test_reset();
        test_cpu_read();
        test_ack_idle();
        test_tie();
        test_dma_write();
        test_req_drop();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
